// File: rtl/apb_lockstep_checker_if.sv
// APB bundle for NUM_DUTS compared channels; lane i of every vector belongs to DUT i.
interface apb_lockstep_checker_if #(
  parameter int NUM_DUTS   = 2,
  parameter int DATA_WIDTH = 32
) ();
  logic [NUM_DUTS-1:0]            psel;
  logic [NUM_DUTS-1:0]            penable;
  logic [NUM_DUTS-1:0]            pwrite;
  logic [NUM_DUTS-1:0]            pready;
  logic [NUM_DUTS-1:0]            pslverr;
  logic [NUM_DUTS*DATA_WIDTH-1:0] prdata;

  modport master  (output psel, penable, pwrite, input  pready, pslverr, prdata);
  modport slave   (input  psel, penable, pwrite, output pready, pslverr, prdata);
  // Passive observer: sees every lane and drives nothing.
  modport monitor (input  psel, penable, pwrite, pready, pslverr, prdata);
endinterface

// File: rtl/apb_lockstep_checker.sv
// N-way APB read-response equivalence checker: per-channel response FIFOs, compare
// against channel 0 when every FIFO holds a response, sticky/counted error reporting.
module apb_lockstep_checker #(
  parameter int NUM_DUTS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT        = 16,
  parameter int COMPARE_SLVERR = 1
) (
  input  logic                                  PCLK,
  input  logic                                  PRESETn,
  apb_lockstep_checker_if.monitor               bus,
  input  logic                                  clr,
  output logic                                  mismatch,
  output logic                                  mismatch_sticky,
  output logic [CNT_WIDTH-1:0]                  mismatch_count,
  output logic [NUM_DUTS-1:0]                   first_mask,
  output logic [DATA_WIDTH-1:0]                 first_ref_data,
  output logic                                  overflow,
  output logic [NUM_DUTS-1:0]                   overflow_mask,
  output logic                                  timeout,
  output logic [NUM_DUTS*($clog2(DEPTH)+1)-1:0] fifo_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = DATA_WIDTH + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [NUM_DUTS-1:0]    push;
  logic [NUM_DUTS-1:0]    not_empty;
  logic [NUM_DUTS-1:0]    accept;
  logic [NUM_DUTS-1:0]    drop;
  logic [NUM_DUTS-1:0]    diff;
  logic [NUM_DUTS*EW-1:0] head_flat;
  logic                   compare;
  logic                   all_empty;
  logic                   hit;

  assign compare   = &not_empty;
  assign all_empty = ~|not_empty;

  for (genvar gi = 0; gi < NUM_DUTS; gi++) begin : g_chan
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;
    logic          full;

    assign push[gi]      = bus.psel[gi] & bus.penable[gi] & bus.pready[gi] & ~bus.pwrite[gi];
    assign not_empty[gi] = (level_reg != '0);
    assign full          = (level_reg == LW'(DEPTH));
    // A full FIFO still takes a push when its head leaves on the same edge.
    assign accept[gi]    = push[gi] & (~full | compare);
    assign drop[gi]      = push[gi] & full & ~compare;
    assign head_flat[gi*EW +: EW]   = mem[rd_ptr_reg];
    assign fifo_level[gi*LW +: LW] = level_reg;

    always_comb begin
      level_next = level_reg;
      if (accept[gi] && !compare) begin
        level_next = level_reg + 1'b1;
      end else if (!accept[gi] && compare) begin
        level_next = level_reg - 1'b1;
      end
    end

    always_ff @(posedge PCLK) begin
      if (accept[gi]) begin
        mem[wr_ptr_reg] <= {bus.pslverr[gi], bus.prdata[gi*DATA_WIDTH +: DATA_WIDTH]};
      end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        level_reg <= level_next;
        if (accept[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (compare)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign diff[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DUTS; gi++) begin : g_diff
    logic data_ne;
    logic err_ne;
    assign data_ne  = head_flat[gi*EW +: DATA_WIDTH] != head_flat[0 +: DATA_WIDTH];
    assign err_ne   = (COMPARE_SLVERR != 0) && (head_flat[gi*EW + DATA_WIDTH] != head_flat[DATA_WIDTH]);
    assign diff[gi] = compare & (data_ne | err_ne);
  end
  assign hit = |diff;

  logic [TW-1:0] tcnt_reg;
  logic [TW-1:0] tcnt_next;

  always_comb begin
    tcnt_next = tcnt_reg;
    if (TIMEOUT == 0 || compare || all_empty) begin
      tcnt_next = '0;
    end else if (tcnt_reg != TW'(TIMEOUT)) begin
      tcnt_next = tcnt_reg + 1'b1;
    end
  end

  logic                  mismatch_reg;
  logic                  sticky_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic [NUM_DUTS-1:0]   first_mask_reg;
  logic [DATA_WIDTH-1:0] first_ref_reg;
  logic                  overflow_reg;
  logic [NUM_DUTS-1:0]   overflow_mask_reg;
  logic                  timeout_reg;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mismatch_reg      <= 1'b0;
      sticky_reg        <= 1'b0;
      count_reg         <= '0;
      first_mask_reg    <= '0;
      first_ref_reg     <= '0;
      overflow_reg      <= 1'b0;
      overflow_mask_reg <= '0;
      timeout_reg       <= 1'b0;
      tcnt_reg          <= '0;
    end else begin
      // The pulse is reported even when clr wipes the sticky state on the same edge.
      mismatch_reg <= hit;
      if (clr) begin
        sticky_reg        <= 1'b0;
        count_reg         <= '0;
        first_mask_reg    <= '0;
        first_ref_reg     <= '0;
        overflow_reg      <= 1'b0;
        overflow_mask_reg <= '0;
        timeout_reg       <= 1'b0;
        tcnt_reg          <= '0;
      end else begin
        tcnt_reg <= tcnt_next;
        if (hit) begin
          sticky_reg <= 1'b1;
          if (count_reg != '1) count_reg <= count_reg + 1'b1;
          if (!sticky_reg) begin
            first_mask_reg <= diff;
            first_ref_reg  <= head_flat[0 +: DATA_WIDTH];
          end
        end
        if (|drop) overflow_reg <= 1'b1;
        overflow_mask_reg <= overflow_mask_reg | drop;
        if (TIMEOUT > 0 && tcnt_next == TW'(TIMEOUT)) timeout_reg <= 1'b1;
      end
    end
  end

  assign mismatch        = mismatch_reg;
  assign mismatch_sticky = sticky_reg;
  assign mismatch_count  = count_reg;
  assign first_mask      = first_mask_reg;
  assign first_ref_data  = first_ref_reg;
  assign overflow        = overflow_reg;
  assign overflow_mask   = overflow_mask_reg;
  assign timeout         = timeout_reg;
endmodule

// File: tb/tb_apb_lockstep_checker.sv
// Bench for apb_lockstep_checker: a 3-channel instance with slverr compare and a 2-channel
// instance without it, both checked against a queue-based model of the response streams.
module tb_apb_lockstep_checker;
  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int TO    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;
  logic clr     = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_lockstep_checker_if #(.NUM_DUTS(N), .DATA_WIDTH(DW)) bus ();
  apb_lockstep_checker_if #(.NUM_DUTS(2), .DATA_WIDTH(DW)) bus2 ();
  assign bus2.psel    = bus.psel[1:0];
  assign bus2.penable = bus.penable[1:0];
  assign bus2.pwrite  = bus.pwrite[1:0];
  assign bus2.pready  = bus.pready[1:0];
  assign bus2.pslverr = bus.pslverr[1:0];
  assign bus2.prdata  = bus.prdata[2*DW-1:0];

  logic            a_mismatch, a_sticky, a_ovf, a_to;
  logic [CW-1:0]   a_count;
  logic [N-1:0]    a_mask, a_ovm;
  logic [DW-1:0]   a_ref;
  logic [N*LW-1:0] a_level;
  logic            b_mismatch, b_sticky, b_ovf, b_to;
  logic [CW-1:0]   b_count;
  logic [1:0]      b_mask, b_ovm;
  logic [DW-1:0]   b_ref;
  logic [2*LW-1:0] b_level;

  apb_lockstep_checker #(.NUM_DUTS(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW),
                         .TIMEOUT(TO), .COMPARE_SLVERR(1)) u_dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus), .clr(clr),
    .mismatch(a_mismatch), .mismatch_sticky(a_sticky), .mismatch_count(a_count),
    .first_mask(a_mask), .first_ref_data(a_ref), .overflow(a_ovf),
    .overflow_mask(a_ovm), .timeout(a_to), .fifo_level(a_level));

  apb_lockstep_checker #(.NUM_DUTS(2), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW),
                         .TIMEOUT(TO), .COMPARE_SLVERR(0)) u_dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus2), .clr(clr),
    .mismatch(b_mismatch), .mismatch_sticky(b_sticky), .mismatch_count(b_count),
    .first_mask(b_mask), .first_ref_data(b_ref), .overflow(b_ovf),
    .overflow_mask(b_ovm), .timeout(b_to), .fifo_level(b_level));

  // Reference model: model 0 = 3 channels with slverr compare, model 1 = 2 channels data only.
  logic [DW:0]   mq [6][$];
  logic          exp_mm [2];
  logic          exp_sticky [2];
  logic          exp_ovf [2];
  logic          exp_to [2];
  int            exp_cnt [2];
  int            tcnt [2];
  logic [N-1:0]  exp_mask [2];
  logic [N-1:0]  exp_ovm [2];
  logic [DW-1:0] exp_ref [2];
  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) mq[i].delete();
    for (int m = 0; m < 2; m++) begin
      exp_mm[m] = 0; exp_sticky[m] = 0; exp_ovf[m] = 0; exp_to[m] = 0;
      exp_cnt[m] = 0; tcnt[m] = 0; exp_mask[m] = '0; exp_ovm[m] = '0; exp_ref[m] = '0;
    end
  endtask

  // Applies the effect of the coming clock edge, given the inputs currently driven.
  task automatic model_edge();
    int n;
    bit cs, cmp, empty_all, mm;
    logic [N-1:0] mask, ovm_new;
    logic [DW:0] h0, h;
    for (int m = 0; m < 2; m++) begin
      n = (m == 0) ? 3 : 2;
      cs = (m == 0);
      cmp = 1; empty_all = 1; mask = '0; ovm_new = '0; h0 = '0;
      for (int c = 0; c < n; c++) begin
        if (mq[m*3+c].size() == 0) cmp = 0;
        else empty_all = 0;
      end
      if (cmp) begin
        h0 = mq[m*3].pop_front();
        for (int c = 1; c < n; c++) begin
          h = mq[m*3+c].pop_front();
          if (h[DW-1:0] != h0[DW-1:0] || (cs && h[DW] != h0[DW])) mask[c] = 1'b1;
        end
      end
      mm = (mask != '0);
      for (int c = 0; c < n; c++) begin
        if (bus.psel[c] && bus.penable[c] && bus.pready[c] && !bus.pwrite[c]) begin
          if (mq[m*3+c].size() < DEPTH) mq[m*3+c].push_back({bus.pslverr[c], bus.prdata[c*DW +: DW]});
          else ovm_new[c] = 1'b1;
        end
      end
      tcnt[m] = (cmp || empty_all) ? 0 : ((tcnt[m] < TO) ? tcnt[m] + 1 : TO);
      exp_mm[m] = mm;
      if (clr) begin
        exp_sticky[m] = 0; exp_cnt[m] = 0; exp_mask[m] = '0; exp_ref[m] = '0;
        exp_ovf[m] = 0; exp_ovm[m] = '0; exp_to[m] = 0; tcnt[m] = 0;
      end else begin
        if (mm) begin
          if (!exp_sticky[m]) begin exp_mask[m] = mask; exp_ref[m] = h0[DW-1:0]; end
          exp_sticky[m] = 1;
          if (exp_cnt[m] < CMAX) exp_cnt[m]++;
        end
        if (ovm_new != '0) begin exp_ovf[m] = 1; exp_ovm[m] = exp_ovm[m] | ovm_new; end
        if (TO > 0 && tcnt[m] == TO) exp_to[m] = 1;
      end
    end
  endtask

  function automatic logic [N*LW-1:0] exp_level(input int m);
    logic [N*LW-1:0] r;
    r = '0;
    for (int c = 0; c < ((m == 0) ? 3 : 2); c++) r[c*LW +: LW] = LW'(mq[m*3+c].size());
    return r;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.psel = '0; bus.penable = '0; bus.pwrite = '0; bus.pready = '0;
    bus.pslverr = '0; bus.prdata = '0; clr = 1'b0;
  endtask

  task automatic drive_read(input int c, input logic [DW-1:0] d, input logic err);
    bus.psel[c] = 1'b1; bus.penable[c] = 1'b1; bus.pready[c] = 1'b1;
    bus.pwrite[c] = 1'b0; bus.pslverr[c] = err; bus.prdata[c*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    drive_idle();
    PRESETn = 1'b0;
    model_reset();
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    #1 PRESETn = 1'b0;
    #2;
    total++; if (a_mismatch !== 1'b0) begin bad++; $display("FAIL rst_mismatch got=%b exp=0", a_mismatch); end
    total++; if (a_sticky !== 1'b0) begin bad++; $display("FAIL rst_sticky got=%b exp=0", a_sticky); end
    total++; if (a_count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", a_count); end
    total++; if (a_mask !== '0) begin bad++; $display("FAIL rst_mask got=%b exp=0", a_mask); end
    total++; if (a_ref !== '0) begin bad++; $display("FAIL rst_ref got=%h exp=0", a_ref); end
    total++; if (a_ovf !== 1'b0 || a_ovm !== '0) begin bad++; $display("FAIL rst_overflow got=%b/%b exp=0/0", a_ovf, a_ovm); end
    total++; if (a_to !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", a_to); end
    total++; if (a_level !== '0) begin bad++; $display("FAIL rst_level got=%h exp=0", a_level); end
    total++; if (b_level !== '0 || b_count !== '0) begin bad++; $display("FAIL rst_b got=%h/%0d exp=0/0", b_level, b_count); end
    model_reset();
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
  endtask

  task automatic test_lockstep_equal();
    logic [N*LW-1:0] lv;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive_idle();
      for (int c = 0; c < N; c++) drive_read(c, 32'hDEADBEEF, 1'b0);
      tick();
      lv = exp_level(0);
      total++; if (a_level !== lv) begin bad++; $display("FAIL eq_level_push%0d got=%h exp=%h", k, a_level, lv); end
      drive_idle();
      tick();
      total++; if (a_level !== '0) begin bad++; $display("FAIL eq_level_pop%0d got=%h exp=0", k, a_level); end
      total++; if (a_mismatch !== exp_mm[0]) begin bad++; $display("FAIL eq_mismatch%0d got=%b exp=%b", k, a_mismatch, exp_mm[0]); end
    end
    tick();
    total++; if (a_mismatch !== 1'b0 || a_count !== '0) begin bad++; $display("FAIL eq_final got=%b/%0d exp=0/0", a_mismatch, a_count); end
  endtask

  task automatic test_mismatch_capture();
    logic [DW-1:0] d;
    apply_reset();
    drive_read(0, 32'h12345679, 1'b0);
    drive_read(1, 32'h12345678, 1'b0);
    drive_read(2, 32'h12345679, 1'b0);
    tick();
    total++; if (a_mismatch !== 1'b0) begin bad++; $display("FAIL mm_early got=%b exp=0", a_mismatch); end
    drive_idle();
    tick();
    total++; if (a_mismatch !== 1'b1) begin bad++; $display("FAIL mm_pulse got=%b exp=1", a_mismatch); end
    total++; if (a_sticky !== 1'b1 || a_count !== 8'd1) begin bad++; $display("FAIL mm_sticky_count got=%b/%0d exp=1/1", a_sticky, a_count); end
    total++; if (a_mask !== 3'b010 || a_ref !== 32'h12345679) begin bad++; $display("FAIL mm_capture got=%b/%h exp=010/12345679", a_mask, a_ref); end
    total++; if (b_mismatch !== exp_mm[1]) begin bad++; $display("FAIL mm_b_pulse got=%b exp=%b", b_mismatch, exp_mm[1]); end
    tick();
    total++; if (a_mismatch !== 1'b0) begin bad++; $display("FAIL mm_one_cycle got=%b exp=0", a_mismatch); end
    d = $urandom;
    drive_read(0, d, 1'b0);
    drive_read(1, d, 1'b0);
    drive_read(2, d ^ 32'h0000_0100, 1'b0);
    tick();
    drive_idle();
    tick();
    total++; if (a_count !== 8'd2) begin bad++; $display("FAIL mm_count2 got=%0d exp=2", a_count); end
    total++; if (a_mask !== 3'b010 || a_ref !== 32'h12345679) begin bad++; $display("FAIL mm_capture_held got=%b/%h exp=010/12345679", a_mask, a_ref); end
    total++; if (b_count !== CW'(exp_cnt[1])) begin bad++; $display("FAIL mm_b_count got=%0d exp=%0d", b_count, exp_cnt[1]); end
  endtask

  task automatic test_drift();
    logic [DW-1:0] d [4];
    logic [N*LW-1:0] lv;
    int peak;
    apply_reset();
    for (int k = 0; k < 4; k++) d[k] = $urandom;
    peak = 0;
    for (int cy = 0; cy < 14; cy++) begin
      drive_idle();
      for (int k = 0; k < 4; k++) begin
        if (cy == 2*k) begin drive_read(0, d[k], 1'b0); drive_read(1, d[k], 1'b0); end
        if (cy == 2*k + 3) drive_read(2, d[k], 1'b0);
      end
      tick();
      lv = exp_level(0);
      total++; if (a_level !== lv) begin bad++; $display("FAIL drift_level_c%0d got=%h exp=%h", cy, a_level, lv); end
      if (int'(a_level[0 +: LW]) > peak) peak = int'(a_level[0 +: LW]);
      if (int'(a_level[LW +: LW]) > peak) peak = int'(a_level[LW +: LW]);
    end
    total++; if (peak != 2) begin bad++; $display("FAIL drift_peak got=%0d exp=2", peak); end
    total++; if (a_count !== '0 || a_sticky !== 1'b0) begin bad++; $display("FAIL drift_mismatch got=%0d/%b exp=0/0", a_count, a_sticky); end
    total++; if (a_ovf !== 1'b0 || a_to !== 1'b0) begin bad++; $display("FAIL drift_ovf_to got=%b/%b exp=0/0", a_ovf, a_to); end
    total++; if (a_level !== '0) begin bad++; $display("FAIL drift_drained got=%h exp=0", a_level); end
  endtask

  task automatic test_overflow_timeout();
    logic [N*LW-1:0] lv;
    int rise;
    apply_reset();
    rise = -1;
    for (int s = 0; s < 40; s++) begin
      drive_idle();
      if (s < 5) drive_read(0, $urandom, 1'b0);
      tick();
      if (a_timeout_seen(rise)) rise = s;
      if (s == 4) begin
        lv = '0; lv[0 +: LW] = LW'(4);
        total++; if (a_level !== lv) begin bad++; $display("FAIL ovf_level got=%h exp=%h", a_level, lv); end
        total++; if (a_ovf !== 1'b1 || a_ovm !== 3'b001) begin bad++; $display("FAIL ovf_flags got=%b/%b exp=1/001", a_ovf, a_ovm); end
        total++; if (b_ovf !== 1'b1 || b_ovm !== 2'b01) begin bad++; $display("FAIL ovf_b_flags got=%b/%b exp=1/01", b_ovf, b_ovm); end
      end
      total++; if (a_to !== exp_to[0]) begin bad++; $display("FAIL to_model_s%0d got=%b exp=%b", s, a_to, exp_to[0]); end
    end
    total++; if (rise != 16) begin bad++; $display("FAIL to_rise got=%0d exp=16", rise); end
    total++; if (b_to !== 1'b1) begin bad++; $display("FAIL to_b got=%b exp=1", b_to); end
  endtask

  function automatic bit a_timeout_seen(input int rise_so_far);
    return (a_to === 1'b1) && (rise_so_far < 0);
  endfunction

  task automatic test_slverr();
    logic [DW-1:0] d;
    apply_reset();
    d = $urandom;
    for (int c = 0; c < N; c++) drive_read(c, d, (c == 1));
    tick();
    drive_idle();
    tick();
    total++; if (a_mismatch !== 1'b1 || a_mask !== 3'b010) begin bad++; $display("FAIL slverr_cmp got=%b/%b exp=1/010", a_mismatch, a_mask); end
    total++; if (b_mismatch !== 1'b0 || b_count !== '0) begin bad++; $display("FAIL slverr_ignored got=%b/%0d exp=0/0", b_mismatch, b_count); end
  endtask

  task automatic test_saturation_clear();
    logic [DW-1:0] d;
    logic [N*LW-1:0] lv;
    apply_reset();
    for (int k = 0; k < 259; k++) begin
      d = $urandom;
      drive_read(0, d, 1'b0); drive_read(1, ~d, 1'b0); drive_read(2, d, 1'b0);
      tick();
    end
    total++; if (a_count !== 8'd255 || exp_cnt[0] != CMAX) begin bad++; $display("FAIL sat_reach got=%0d exp=255 (model %0d)", a_count, exp_cnt[0]); end
    tick();
    total++; if (a_mismatch !== 1'b1 || a_count !== 8'd255) begin bad++; $display("FAIL sat_hold got=%b/%0d exp=1/255", a_mismatch, a_count); end
    total++; if (a_mask !== 3'b010) begin bad++; $display("FAIL sat_mask got=%b exp=010", a_mask); end
    drive_idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++; if (a_mismatch !== 1'b1) begin bad++; $display("FAIL clr_pulse got=%b exp=1", a_mismatch); end
    total++; if (a_sticky !== 1'b0 || a_count !== '0) begin bad++; $display("FAIL clr_wins got=%b/%0d exp=0/0", a_sticky, a_count); end
    total++; if (a_mask !== '0 || a_ref !== '0) begin bad++; $display("FAIL clr_capture got=%b/%h exp=0/0", a_mask, a_ref); end
    tick();
    for (int k = 0; k < 6; k++) begin
      drive_idle(); drive_read(0, $urandom, 1'b0); tick();
    end
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL clr_pre_ovf got=%b exp=1", a_ovf); end
    drive_idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    lv = '0; lv[0 +: LW] = LW'(4);
    total++; if (a_level !== lv || a_level !== exp_level(0)) begin bad++; $display("FAIL clr_level_kept got=%h exp=%h", a_level, lv); end
    total++; if (a_ovf !== 1'b0 || a_ovm !== '0 || a_to !== 1'b0) begin bad++; $display("FAIL clr_flags got=%b/%b/%b exp=0/0/0", a_ovf, a_ovm, a_to); end
  endtask

  task automatic test_async_reset();
    logic [N*LW-1:0] lv;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive_idle(); drive_read(0, $urandom, 1'b0); drive_read(1, $urandom, 1'b0); tick();
    end
    drive_idle();
    lv = exp_level(0);
    total++; if (a_level !== lv) begin bad++; $display("FAIL arst_pre got=%h exp=%h", a_level, lv); end
    #2 PRESETn = 1'b0;
    #1;
    total++; if (a_level !== '0 || b_level !== '0) begin bad++; $display("FAIL arst_level got=%h/%h exp=0/0", a_level, b_level); end
    model_reset();
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
  endtask

  task automatic test_random();
    logic [N*LW-1:0] lv, lvb;
    apply_reset();
    for (int cy = 0; cy < 500; cy++) begin
      for (int c = 0; c < N; c++) begin
        bus.psel[c]    = ($urandom_range(0, 3) != 0);
        bus.penable[c] = ($urandom_range(0, 3) != 0);
        bus.pready[c]  = ($urandom_range(0, 2) != 0);
        bus.pwrite[c]  = ($urandom_range(0, 3) == 0);
        bus.pslverr[c] = ($urandom_range(0, 7) == 0);
        bus.prdata[c*DW +: DW] = 32'hA5A5_0000 | 32'($urandom_range(0, 1));
      end
      clr = ($urandom_range(0, 63) == 0);
      tick();
      lv = exp_level(0);
      lvb = exp_level(1);
      total++; if (a_mismatch !== exp_mm[0]) begin bad++; $display("FAIL rnd_mm c%0d got=%b exp=%b", cy, a_mismatch, exp_mm[0]); end
      total++; if (a_sticky !== exp_sticky[0]) begin bad++; $display("FAIL rnd_sticky c%0d got=%b exp=%b", cy, a_sticky, exp_sticky[0]); end
      total++; if (a_count !== CW'(exp_cnt[0])) begin bad++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", cy, a_count, exp_cnt[0]); end
      total++; if (a_mask !== exp_mask[0] || a_ref !== exp_ref[0]) begin bad++; $display("FAIL rnd_capture c%0d got=%b/%h exp=%b/%h", cy, a_mask, a_ref, exp_mask[0], exp_ref[0]); end
      total++; if (a_ovf !== exp_ovf[0] || a_ovm !== exp_ovm[0]) begin bad++; $display("FAIL rnd_ovf c%0d got=%b/%b exp=%b/%b", cy, a_ovf, a_ovm, exp_ovf[0], exp_ovm[0]); end
      total++; if (a_to !== exp_to[0]) begin bad++; $display("FAIL rnd_to c%0d got=%b exp=%b", cy, a_to, exp_to[0]); end
      total++; if (a_level !== lv) begin bad++; $display("FAIL rnd_level c%0d got=%h exp=%h", cy, a_level, lv); end
      total++; if (b_mismatch !== exp_mm[1] || b_count !== CW'(exp_cnt[1])) begin bad++; $display("FAIL rnd_b_mm c%0d got=%b/%0d exp=%b/%0d", cy, b_mismatch, b_count, exp_mm[1], exp_cnt[1]); end
      total++; if (b_level !== lvb[2*LW-1:0]) begin bad++; $display("FAIL rnd_b_level c%0d got=%h exp=%h", cy, b_level, lvb[2*LW-1:0]); end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_lockstep_equal();
    test_mismatch_capture();
    test_drift();
    test_overflow_timeout();
    test_slverr();
    test_saturation_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
